// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
package imm_pkg;

  // Widest supported datapath; the extractor always builds a 64-bit immediate.
  localparam int unsigned IMM_W = 64;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    fmt_e             fmt;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream valid-ready bus of the immediate-decode stage.
// out_illegal exists only when IMM_ILLEGAL_CHECK_EN is defined.
interface imm_decode_stage_if
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
  logic            out_illegal;
`endif

  // Driver of instructions and consumer of decoded results.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
`ifdef IMM_ILLEGAL_CHECK_EN
    , input out_illegal
`endif
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
`ifdef IMM_ILLEGAL_CHECK_EN
    , output out_illegal
`endif
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction and format classification.
// Optional macro: IMM_ILLEGAL_CHECK_EN (flags unrecognised encodings).
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_shift;
  logic [IMM_W-1:0] w_imm_i;
  logic [IMM_W-1:0] w_imm_s;
  logic [IMM_W-1:0] w_imm_b;
  logic [IMM_W-1:0] w_imm_u;
  logic [IMM_W-1:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_shift  = (w_opcode == OP_IMM) && (w_funct3[1:0] == 2'b01);

  assign w_imm_i = {{(IMM_W-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{(IMM_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(IMM_W-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {{(IMM_W-32){i_instr[31]}}, i_instr[31:12], 12'b0};
  assign w_imm_j = {{(IMM_W-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

`ifdef IMM_ILLEGAL_CHECK_EN
  // Shift funct7/funct6 may only carry the arithmetic-shift bit (instr[30]).
  logic w_shift_f7_ok;
  assign w_shift_f7_ok = (i_instr[31] == 1'b0) && (i_instr[29:20+SHAMT_W] == '0);
`endif

  // Select the immediate and format class from the opcode.
  always_comb begin
    o_dec = '0;
    if (i_instr[1:0] == 2'b11) begin
      case (w_opcode)
        OP_IMM: begin
          o_dec.fmt = FMT_I;
          o_dec.imm = w_shift ? IMM_W'(i_instr[20 +: SHAMT_W]) : w_imm_i;
        end
        LOAD, JALR, MISC_MEM: begin
          o_dec.fmt = FMT_I;
          o_dec.imm = w_imm_i;
        end
        SYSTEM: begin
          o_dec.fmt = FMT_I;
          o_dec.imm = w_funct3[2] ? IMM_W'(i_instr[19:15]) : w_imm_i;
        end
        STORE: begin
          o_dec.fmt = FMT_S;
          o_dec.imm = w_imm_s;
        end
        BRANCH: begin
          o_dec.fmt = FMT_B;
          o_dec.imm = w_imm_b;
        end
        LUI, AUIPC: begin
          o_dec.fmt = FMT_U;
          o_dec.imm = w_imm_u;
        end
        JAL: begin
          o_dec.fmt = FMT_J;
          o_dec.imm = w_imm_j;
        end
        OP: o_dec.fmt = FMT_R;
        default: ;
      endcase
    end
`ifdef IMM_ILLEGAL_CHECK_EN
    o_dec.illegal = (o_dec.fmt == FMT_NONE) || (w_shift && !w_shift_f7_ok);
`endif
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer (M + K).
// in_ready is a pure register; out_* come straight from the M register.
// Optional macro: IMM_ILLEGAL_CHECK_EN (adds out_illegal).
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  decoded_t w_dec;
  entry_t   w_new;
  entry_t   r_m;
  entry_t   r_k;
  entry_t   w_m_nxt;
  entry_t   w_k_nxt;
  logic     r_m_valid;
  logic     r_k_valid;
  logic     r_in_ready;
  logic     w_m_valid_nxt;
  logic     w_k_valid_nxt;
  logic     w_accept;
  logic     w_drain;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .i_instr (bus.in_instr),
    .o_dec   (w_dec)
  );

  // Upper immediate bits are pure sign copies when XLEN is narrower.
  if (XLEN < IMM_W) begin : g_narrow
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^w_dec.imm[IMM_W-1:XLEN];
  end

  // Pack the incoming instruction with its decoded fields.
  always_comb begin
    w_new         = '0;
    w_new.instr   = bus.in_instr;
    w_new.pc      = bus.in_pc;
    w_new.imm     = w_dec.imm[XLEN-1:0];
    w_new.fmt     = w_dec.fmt;
    w_new.illegal = w_dec.illegal;
  end

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_drain  = r_m_valid & bus.out_ready;

  // Next-state of the M/K pair; K only fills when M is stalled.
  always_comb begin
    w_m_nxt       = r_m;
    w_k_nxt       = r_k;
    w_m_valid_nxt = r_m_valid;
    w_k_valid_nxt = r_k_valid;
    if (r_k_valid) begin
      if (w_drain) begin
        w_m_nxt       = r_k;
        w_k_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_m_valid || bus.out_ready) begin
        w_m_nxt       = w_new;
        w_m_valid_nxt = 1'b1;
      end else begin
        w_k_nxt       = w_new;
        w_k_valid_nxt = 1'b1;
      end
    end else if (w_drain) begin
      w_m_valid_nxt = 1'b0;
    end
  end

  // State registers; reset discards both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_k        <= '0;
      r_m_valid  <= 1'b0;
      r_k_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_nxt;
      r_k        <= w_k_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_k_valid  <= w_k_valid_nxt;
      r_in_ready <= !w_k_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_m_valid;
  assign bus.out_instr = r_m.instr;
  assign bus.out_pc    = r_m.pc;
  assign bus.out_imm   = r_m.imm;
  assign bus.out_fmt   = r_m.fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
  assign bus.out_illegal = r_m.illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = r_m.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed scoreboard bench for imm_decode_stage (XLEN=32 main DUT, XLEN=64 side DUT).
module tb_imm_decode_stage;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  int   cyc      = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  exp_t sb[$];
  int   pop_log[$];

  imm_decode_stage_if #(.XLEN(32)) bus ();
  imm_decode_stage_if #(.XLEN(64)) bus64 ();

  imm_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, wait for acceptance, record its expected result.
  task automatic send(input logic [31:0] ins, input logic [31:0] imm, input fmt_e fmt,
                      input logic ill);
    int   guard;
    exp_t e;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc_ctr;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      chk("send_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      e.instr = ins; e.pc = pc_ctr; e.imm = imm; e.fmt = fmt; e.ill = ill;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic drain_wait();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Compare each transferred output against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
        chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("out_imm", 64'(bus.out_imm), 64'(e.imm));
        chk("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
`ifdef IMM_ILLEGAL_CHECK_EN
        chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
`endif
      end
      n_pop++;
      pop_log.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
`ifdef IMM_ILLEGAL_CHECK_EN
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate stream over every format
    send(32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);  // addi x1,x0,-1
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    chk("latency_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    send(32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0);  // beq x0,x0,-4
    send(32'h4030D093, 32'h00000003, FMT_I, 1'b0);  // srai x1,x1,3
    send(32'h0020A423, 32'h00000008, FMT_S, 1'b0);  // sw x2,8(x1)
    send(32'hFE20AE23, 32'hFFFFFFFC, FMT_S, 1'b0);  // sw x2,-4(x1)
    send(32'h123450B7, 32'h12345000, FMT_U, 1'b0);  // lui x1,0x12345
    send(32'h80000097, 32'h80000000, FMT_U, 1'b0);  // auipc x1,0x80000
    send(32'hFF9FF06F, 32'hFFFFFFF8, FMT_J, 1'b0);  // jal x0,-8
    send(32'h002081B3, 32'h00000000, FMT_R, 1'b0);  // add x3,x1,x2
    send(32'h3002D073, 32'h00000005, FMT_I, 1'b0);  // csrrwi x0,mstatus,5
    send(32'h800020F3, 32'hFFFFF800, FMT_I, 1'b0);  // csrrs x1,0x800,x0
    send(32'hFF012083, 32'hFFFFFFF0, FMT_I, 1'b0);  // lw x1,-16(x2)
    send(32'h00000000, 32'h00000000, FMT_NONE, 1'b1);
    send(32'h00000001, 32'h00000000, FMT_NONE, 1'b1);
    send(32'hFFFFFFFF, 32'h00000000, FMT_NONE, 1'b1);
    send(32'hFE109093, 32'h00000001, FMT_I, 1'b1);  // slli with bad funct7
    drain_wait();

    // Backpressure: four instructions, out_ready low for three edges
    bus.out_ready = 1'b0;
    base = n_pop;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        send(32'h123450B7, 32'h12345000, FMT_U, 1'b0);
        send(32'hFE20AE23, 32'hFFFFFFFC, FMT_S, 1'b0);
        send(32'hFF9FF06F, 32'hFFFFFFF8, FMT_J, 1'b0);
        send(32'h3002D073, 32'h00000005, FMT_I, 1'b0);
      end
      begin
        @(posedge clk); #2 chk("bp_ready_e1", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #2 chk("bp_ready_e2", 64'(bus.in_ready), 64'd0);
        chk("bp_valid_e2", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #2 chk("bp_ready_e3", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #2 chk("bp_ready_e4", 64'(bus.in_ready), 64'd1);
      end
    join
    drain_wait();
    chk("bp_count", 64'(n_pop - base), 64'd4);
    n = pop_log.size();
    chk("bp_tput_a", 64'(pop_log[n-1] - pop_log[n-2]), 64'd1);
    chk("bp_tput_b", 64'(pop_log[n-2] - pop_log[n-3]), 64'd1);

    // Reset asserted while both entries are full
    bus.out_ready = 1'b0;
    send(32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    send(32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("midrst_out_imm", 64'(bus.out_imm), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = n_pop;
    send(32'h4030D093, 32'h00000003, FMT_I, 1'b0);
    drain_wait();
    chk("post_rst_count", 64'(n_pop - base), 64'd1);

    // XLEN=64 instance, always ready downstream
    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h800000B7;  // lui x1,0x80000
    bus64.in_pc    = 64'h0000_0001_0000_0000;
    @(posedge clk); #1;
    bus64.in_instr = 32'h4210D093;  // srai x1,x1,33
    bus64.in_pc    = 64'h0000_0001_0000_0004;
    chk("x64_lui_valid", 64'(bus64.out_valid), 64'd1);
    chk("x64_lui_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    chk("x64_lui_fmt", 64'(bus64.out_fmt), 64'(FMT_U));
    chk("x64_lui_pc", bus64.out_pc, 64'h0000_0001_0000_0000);
    @(posedge clk); #1;
    bus64.in_instr = 32'hFFF00093;  // addi x1,x0,-1
    chk("x64_srai_imm", bus64.out_imm, 64'h21);
    chk("x64_srai_fmt", 64'(bus64.out_fmt), 64'(FMT_I));
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    chk("x64_addi_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    @(posedge clk); #1;
    chk("x64_idle_valid", 64'(bus64.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
